mon_dff: RTL and testbench
==========================

Name: mon_dff

Overview:
- Output-side companion to the dff stimulus driver in the dff bench.
- It is a passive monitor/scoreboard. The scenario pushes expected values, and the block samples DUT dout, compares it against the expected queue head, and counts passes and fails.
- It raises a done/result code that the top polls through the s2cif check_end path before calling $finish.
- Synthesizable style: one clock, async active-low reset.

Parameters:
- ID, 1, instance number used in trace messages and the result word.
- WIDTH, 1, width of the monitored data and expected data.
- DEPTH, 8, expected-queue entries; power of two, minimum 2.
- CNT_W, 16, width of the pass and fail counters.

Ports:
- clk  in  1  bench clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset: asserts immediately on 0, releases on the clk rising edge after the 0-to-1 transition.
- exp_valid  in  1  the scenario is presenting an expected value.
- exp_data  in  WIDTH  the expected value.
- exp_ready  out  1  queue not full; a push occurs when exp_valid&&exp_ready.
- smp_en  in  1  sample dout this cycle; asserted by the driver one cycle after it drives din.
- dout  in  WIDTH  DUT output under test.
- end_req  in  1  single-cycle pulse: the scenario has finished issuing stimulus.
- done  out  1  the check has ended; sticky until reset.
- result  out  2  0 = running, 1 = pass, 2 = fail, 3 = protocol error.
- pass_cnt  out  CNT_W  number of matching compares.
- fail_cnt  out  CNT_W  number of mismatching compares.
- err  out  1  sticky underflow/overflow flag.

Behaviour:
- Reset values: exp_ready=1, done=0, result=0, pass_cnt=0, fail_cnt=0, err=0, queue empty, FSM in IDLE.
- Push: on exp_valid&&exp_ready, exp_data is written at the write pointer. Pointers are log2(DEPTH)+1 bits wide, with the MSB used for full/empty. exp_ready=0 when the queue is full.
- exp_valid while full: no write, err set to 1.
- Compare: on smp_en with the queue non-empty, pop the head and compare it to dout in the same cycle. Counters update on the next edge, so latency is 1 cycle from sample to counter.
  - Equal: pass_cnt increments.
  - Not equal: fail_cnt increments.
  - Counters saturate at all-ones and never wrap.
- smp_en with the queue empty: no pop, no count, err set to 1.
- Simultaneous push and pop:
  - Allowed in the same cycle.
  - When the queue is full, the pop frees a slot but exp_ready is still 0 that cycle. The push is refused and err is set.
  - When the queue is empty, the pop does not see the same-cycle push. Underflow is flagged.
- FSM states:
  - IDLE: moves to RUN on the first push.
  - RUN: moves to DRAIN on end_req.
  - DRAIN: stays until the queue is empty, then moves to DONE.
  - DONE: terminal; pushes and samples are ignored and not flagged.
  - end_req in IDLE goes directly to DONE with result=3 (no checks were performed).
  - end_req in DRAIN or DONE is ignored.
- On entry to DONE:
  - done=1.
  - result=3 if err is set; otherwise 2 if fail_cnt is non-zero; otherwise 1.
  - result is frozen from then on.
- The top's check_end returns a non-zero value once done is set; the value is result in bits 1:0 and ID in bits 15:8.
- Reset mid-operation clears everything immediately, including sticky flags and queue contents. Checks never straddle a reset.

Optional Feature:
- Macro MON_DFF_TRACE_EN.
- Defined: simulation-only $display on every compare and error: time, ID, expected value, dout, pass/fail/under/over.
- Defined: on entry to DONE, print the summary line "mon_dff[ID] result=R pass=P fail=F".
- Undefined: no display code at all; behaviour and ports are identical.

Decomposition:
- Package mon_pkg:
  - mon_state_t enum {IDLE, RUN, DRAIN, DONE}.
  - Result codes RES_RUN=0, RES_PASS=1, RES_FAIL=2, RES_PERR=3.
  - Function for the check_end word.
- One sub-module, mon_fifo, parameterized by WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty.
  - Owns the pointers and storage.
- The mon_dff top holds the FSM, compare logic, counters and flags.

Test Plan:
- Push 4 values 1,0,1,1; drive the matching dout with smp_en ×4; then end_req -> pass_cnt=4, fail_cnt=0, done=1, result=1, err=0.
- Push 1,1,0; dout 1,0,0; end_req -> pass_cnt=2, fail_cnt=1, result=2.
- Push 9 values with smp_en=0 -> exp_ready=0 after 8 values; the 9th is refused; err=1. After drain, result=3.
- smp_en with the queue empty in RUN -> no count change, err=1. After end_req and drain, result=3.
- Push 3 values; end_req; then 3 samples -> the FSM stays in DRAIN until the 3rd sample, then done=1 on the following edge.
- Assert rst=0 in RUN with pass_cnt=2 and 2 entries queued -> all outputs return to reset values immediately. After release, pushing 1 and sampling a matching dout gives pass_cnt=1.

Source files
------------

// File: rtl/mon_pkg.sv
// mon_pkg: shared types for the dff output monitor.
// FSM states, result codes and the check_end word packer.
package mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_t;

    localparam logic [1:0] RES_RUN  = 2'd0;
    localparam logic [1:0] RES_PASS = 2'd1;
    localparam logic [1:0] RES_FAIL = 2'd2;
    localparam logic [1:0] RES_PERR = 2'd3;

    // Word returned by check_end: zero while running,
    // otherwise {id, 6'b0, result}.
    function automatic logic [15:0] check_word(
        input logic       done,
        input logic [7:0] id,
        input logic [1:0] res
    );
        return done ? {id, 6'b0, res} : 16'h0000;
    endfunction

endpackage

// File: rtl/mon_fifo.sv
// mon_fifo: expected-value queue for mon_dff.
// Ports: clk, rst (async low), push, pop, din, dout (head), full, empty.
module mon_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    // Extra MSB distinguishes full from empty when
    // the low address bits coincide.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + ONE;
            if (pop)  rptr <= rptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/mon_dff.sv
// mon_dff: passive monitor/scoreboard for the dff bench.
// Optional trace output: define MON_DFF_TRACE_EN.
// Ports: clk, rst (async low); exp_valid/exp_data/exp_ready push
// expected values; smp_en/dout sample the DUT; end_req ends the
// check; done, result, pass_cnt, fail_cnt, err report status.
module mon_dff
    import mon_pkg::*;
#(
    parameter int ID    = 1,
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exp_valid,
    input  logic [WIDTH-1:0] exp_data,
    output logic             exp_ready,
    input  logic             smp_en,
    input  logic [WIDTH-1:0] dout,
    input  logic             end_req,
    output logic             done,
    output logic [1:0]       result,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mon_state_t       state;
    mon_state_t       state_n;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] head;
    logic             live;
    logic             push;
    logic             pop;
    logic             ovf;
    logic             unf;
    logic             match;
    logic             err_n;
    logic [CNT_W-1:0] pass_n;
    logic [CNT_W-1:0] fail_n;
    logic [1:0]       res_n;

    mon_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (exp_data),
        .dout (head),
        .full (full),
        .empty(empty)
    );

    // exp_ready reflects the registered fill level, so a
    // same-cycle pop never frees a slot for a same-cycle push.
    assign exp_ready = !full;
    assign live      = (state != DONE);
    assign push      = live && exp_valid && !full;
    assign pop       = live && smp_en && !empty;
    assign ovf       = live && exp_valid && full;
    assign unf       = live && smp_en && empty;
    assign match     = (head == dout);
    assign err_n     = err || ovf || unf;

    always_comb begin
        pass_n = pass_cnt;
        fail_n = fail_cnt;
        if (pop && match && pass_cnt != CNT_MAX)
            pass_n = pass_cnt + CNT_ONE;
        if (pop && !match && fail_cnt != CNT_MAX)
            fail_n = fail_cnt + CNT_ONE;
    end

    // res_n is only consumed on the transition into DONE.
    always_comb begin
        state_n = state;
        res_n   = RES_RUN;
        unique case (state)
            IDLE: begin
                if (end_req) begin
                    state_n = DONE;
                    res_n   = RES_PERR;
                end else if (push) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (end_req) state_n = DRAIN;
            end
            DRAIN: begin
                if (empty) begin
                    state_n = DONE;
                    unique case (1'b1)
                        err_n:         res_n = RES_PERR;
                        (fail_n != 0): res_n = RES_FAIL;
                        default:       res_n = RES_PASS;
                    endcase
                end
            end
            default: state_n = DONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            done     <= 1'b0;
            result   <= RES_RUN;
            pass_cnt <= '0;
            fail_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            pass_cnt <= pass_n;
            fail_cnt <= fail_n;
            err      <= err_n;
            if (live && state_n == DONE) begin
                done   <= 1'b1;
                result <= res_n;
            end
        end
    end

`ifdef MON_DFF_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            if (pop)
                $display("%0t mon_dff[%0d] exp=%h dout=%h %s",
                         $time, ID, head, dout,
                         match ? "pass" : "fail");
            if (unf)
                $display("%0t mon_dff[%0d] exp=- dout=%h under",
                         $time, ID, dout);
            if (ovf)
                $display("%0t mon_dff[%0d] exp=%h dout=- over",
                         $time, ID, exp_data);
            if (live && state_n == DONE)
                $display("mon_dff[%0d] result=%0d pass=%0d fail=%0d",
                         ID, res_n, pass_n, fail_n);
        end
    end
`endif

endmodule

// File: tb/tb_mon_dff.sv
// tb_mon_dff: randomized self-checking bench for mon_dff.
// A queue-based scoreboard model predicts every output.
module tb_mon_dff;
    import mon_pkg::*;

    localparam int ID    = 5;
    localparam int W     = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          exp_valid;
    logic [W-1:0]  exp_data;
    logic          exp_ready;
    logic          smp_en;
    logic [W-1:0]  dout;
    logic          end_req;
    logic          done;
    logic [1:0]    result;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic          err;

    int checks = 0;
    int passes = 0;

    // Model: 0 idle, 1 run, 2 drain, 3 done.
    int m_q[$];
    int m_st;
    int m_pass;
    int m_fail;
    bit m_err;
    bit m_done;
    int m_res;

    mon_dff #(
        .ID   (ID),
        .WIDTH(W),
        .DEPTH(DEPTH),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .exp_valid(exp_valid),
        .exp_data (exp_data),
        .exp_ready(exp_ready),
        .smp_en   (smp_en),
        .dout     (dout),
        .end_req  (end_req),
        .done     (done),
        .result   (result),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_st   = 0;
        m_pass = 0;
        m_fail = 0;
        m_err  = 0;
        m_done = 0;
        m_res  = 0;
    endtask

    task automatic quiet();
        exp_valid = 0;
        exp_data  = '0;
        smp_en    = 0;
        dout      = '0;
        end_req   = 0;
    endtask

    // Advance the model with the current inputs, then the DUT.
    task automatic tick();
        bit live;
        bit was_empty;
        bit was_full;
        bit pushed;
        int e;
        live      = (m_st != 3);
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == DEPTH);
        pushed    = 0;
        if (live && smp_en) begin
            if (was_empty) m_err = 1;
            else begin
                e = m_q.pop_front();
                if (e == int'(dout)) begin
                    if (m_pass < CMAX) m_pass++;
                end else begin
                    if (m_fail < CMAX) m_fail++;
                end
            end
        end
        if (live && exp_valid) begin
            if (was_full) m_err = 1;
            else begin
                m_q.push_back(int'(exp_data));
                pushed = 1;
            end
        end
        case (m_st)
            0: if (end_req) begin
                m_st = 3; m_done = 1; m_res = 3;
            end else if (pushed) m_st = 1;
            1: if (end_req) m_st = 2;
            2: if (was_empty) begin
                m_st   = 3;
                m_done = 1;
                m_res  = m_err ? 3 : (m_fail != 0) ? 2 : 1;
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        quiet();
    endtask

    task automatic do_reset();
        quiet();
        @(negedge clk);
        rst = 0;
        model_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic push_val(input int v);
        exp_valid = 1;
        exp_data  = W'(v);
        tick();
    endtask

    task automatic sample(input int v);
        smp_en = 1;
        dout   = W'(v);
        tick();
    endtask

    task automatic finish_run();
        end_req = 1;
        tick();
        for (int i = 0; i < 20 && !m_done; i++) tick();
        checks++;
        if (!m_done || done !== 1'b1)
            $display("FAIL finish_done got=%b want=1 model=%b",
                     done, m_done);
        else passes++;
    endtask

    task automatic test_reset();
        quiet();
        rst = 0;
        model_reset();
        #12;
        checks++;
        if ({exp_ready, done, result, pass_cnt, fail_cnt, err} !==
            {1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0})
            $display("FAIL reset rdy=%b done=%b res=%0d p=%0d f=%0d e=%b",
                     exp_ready, done, result, pass_cnt, fail_cnt, err);
        else passes++;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_pass();
        int v[4] = '{1, 0, 1, 1};
        do_reset();
        foreach (v[i]) push_val(v[i]);
        foreach (v[i]) sample(v[i]);
        finish_run();
        checks++;
        if (pass_cnt !== 4'd4 || fail_cnt !== 4'd0 ||
            result !== RES_PASS || err !== 1'b0)
            $display("FAIL pass p=%0d f=%0d res=%0d e=%b want 4 0 1 0",
                     pass_cnt, fail_cnt, result, err);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            exp_valid = 1;
            smp_en    = 1;
            tick();
        end
        checks++;
        if (err !== 1'b0 || pass_cnt !== 4'd4 || result !== RES_PASS)
            $display("FAIL done_ignore e=%b p=%0d res=%0d want 0 4 1",
                     err, pass_cnt, result);
        else passes++;
    endtask

    task automatic test_mismatch();
        do_reset();
        push_val(1); push_val(1); push_val(0);
        sample(1); sample(0); sample(0);
        finish_run();
        checks++;
        if (pass_cnt !== 4'd2 || fail_cnt !== 4'd1 ||
            result !== RES_FAIL)
            $display("FAIL mismatch p=%0d f=%0d res=%0d want 2 1 2",
                     pass_cnt, fail_cnt, result);
        else passes++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) push_val($urandom_range(15));
        checks++;
        if (exp_ready !== 1'b0 || err !== 1'b0)
            $display("FAIL full rdy=%b e=%b want 0 0", exp_ready, err);
        else passes++;
        push_val(9);
        checks++;
        if (err !== 1'b1 || m_q.size() != 8)
            $display("FAIL overflow e=%b want 1", err);
        else passes++;
        end_req = 1;
        tick();
        while (m_q.size() > 0) sample(m_q[0]);
        finish_run();
        checks++;
        if (result !== RES_PERR || pass_cnt !== 4'd8)
            $display("FAIL ovf_res res=%0d p=%0d want 3 8",
                     result, pass_cnt);
        else passes++;
    endtask

    task automatic test_underflow();
        do_reset();
        push_val(3);
        sample(3);
        sample(3);
        checks++;
        if (err !== 1'b1 || pass_cnt !== 4'd1 || fail_cnt !== 4'd0)
            $display("FAIL underflow e=%b p=%0d f=%0d want 1 1 0",
                     err, pass_cnt, fail_cnt);
        else passes++;
        finish_run();
        checks++;
        if (result !== RES_PERR)
            $display("FAIL unf_res got=%0d want 3", result);
        else passes++;
    endtask

    task automatic test_drain();
        int bad = 0;
        do_reset();
        push_val(2); push_val(7); push_val(4);
        end_req = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            sample(m_q[0]);
            if (done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0)
            $display("FAIL drain_early got=%0d want=0", bad);
        else passes++;
        tick();
        checks++;
        if (done !== 1'b1 || result !== RES_PASS)
            $display("FAIL drain_done done=%b res=%0d want 1 1",
                     done, result);
        else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) push_val(i + 4);
        sample(4); sample(5);
        checks++;
        if (pass_cnt !== 4'd2)
            $display("FAIL mid_pre got=%0d want=2", pass_cnt);
        else passes++;
        rst = 0;
        #1;
        checks++;
        if ({exp_ready, done, result, pass_cnt, fail_cnt, err} !==
            {1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0})
            $display("FAIL mid_reset rdy=%b done=%b p=%0d e=%b",
                     exp_ready, done, pass_cnt, err);
        else passes++;
        model_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        push_val(1);
        sample(1);
        checks++;
        if (pass_cnt !== 4'd1 || err !== 1'b0)
            $display("FAIL mid_after p=%0d e=%b want 1 0", pass_cnt, err);
        else passes++;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            push_val($urandom_range(15));
            for (int c = 0; c < 200; c++) begin
                exp_valid = ($urandom_range(99) < 55);
                exp_data  = W'($urandom_range(15));
                smp_en    = ($urandom_range(99) < 50);
                if (m_q.size() > 0 && $urandom_range(99) < 75)
                    dout = W'(m_q[0]);
                else
                    dout = W'($urandom_range(15));
                end_req   = (c > 150 && $urandom_range(99) < 3);
                tick();
                if (exp_ready !== (m_q.size() < DEPTH) ||
                    done !== m_done || int'(result) != m_res ||
                    int'(pass_cnt) != m_pass ||
                    int'(fail_cnt) != m_fail || err !== m_err) begin
                    if (bad < 5)
                        $display("FAIL rand c=%0d p=%0d/%0d f=%0d/%0d e=%b/%b d=%b/%b",
                                 c, pass_cnt, m_pass, fail_cnt, m_fail,
                                 err, m_err, done, m_done);
                    bad++;
                end
            end
            checks++;
            if (bad != 0) begin
                $display("FAIL rand_run got=%0d want=0 errors", bad);
                bad = 0;
            end else passes++;
        end
    endtask

    task automatic test_word();
        logic [15:0] w;
        w = check_word(done, 8'(ID), result);
        checks++;
        if (w !== {8'(ID), 6'b0, result} || done !== 1'b1)
            $display("FAIL word got=%h done=%b", w, done);
        else passes++;
        w = check_word(1'b0, 8'(ID), result);
        checks++;
        if (w !== 16'h0000)
            $display("FAIL word_run got=%h want=0000", w);
        else passes++;
    endtask

    initial begin
        rst = 1;
        quiet();
        test_reset();
        test_pass();
        test_word();
        test_mismatch();
        test_overflow();
        test_underflow();
        test_drain();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
